// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Optional build macro I2C_NACK_ABORT_EN: a sampled NACK cuts the frame short to STOP.
module i2c_master_ctrl #(
  parameter int unsigned DIVIDE_BY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);

`ifdef I2C_NACK_ABORT_EN
  localparam bit NACK_ABORT = 1'b1;
`else
  localparam bit NACK_ABORT = 1'b0;
`endif

  localparam int unsigned DIV_W = $clog2(DIVIDE_BY);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIVIDE_BY - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(DIVIDE_BY / 2);
  localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'((3 * DIVIDE_BY) / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_READ,
    S_DATA_ACK,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic             nack_q, nack_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             ready_q, ready_d;
  logic             sda_low_q, sda_low_d;
  logic             scl_low_q, scl_low_d;

  logic sda_in;
  logic slot_end;
  logic sample_pt;

  assign sda_in    = i2c_sda;
  assign slot_end  = (div_q == DIV_LAST);
  assign sample_pt = (div_q == DIV_SAMPLE);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    nack_d     = nack_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;

    if (state_q != S_IDLE) begin
      div_d = slot_end ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        div_d   = '0;
        if (enable) begin
          state_d = S_START;
          ready_d = 1'b0;
          shift_d = {addr, rw};
          wdata_d = data_in;
          rw_d    = rw;
          nack_d  = 1'b0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_ADDR;
          bit_d   = '0;
        end
      end
      S_ADDR: begin
        if (slot_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_ADDR_ACK;
          end
        end
      end
      S_ADDR_ACK: begin
        if (sample_pt) begin
          nack_d = sda_in;
        end
        if (slot_end) begin
          bit_d = '0;
          if (NACK_ABORT && nack_d) begin
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
            shift_d = wdata_q;
          end
        end
      end
      S_WRITE: begin
        if (slot_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_DATA_ACK;
          end
        end
      end
      S_READ: begin
        if (sample_pt) begin
          rx_d = {rx_q[6:0], sda_in};
        end
        // rx_d already holds the last bit when sample and slot end coincide
        if (slot_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d    = S_DATA_ACK;
            data_out_d = rx_d;
          end
        end
      end
      S_DATA_ACK: begin
        if (sample_pt && !rw_q) begin
          nack_d = sda_in;
        end
        if (slot_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pad drive is decoded from the next state so the registered lines line up with state_q/div_q.
  always_comb begin
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: begin
        sda_low_d = (div_d >= DIV_HALF);
      end
      S_ADDR, S_WRITE: begin
        scl_low_d = (div_d < DIV_HALF);
        sda_low_d = !shift_d[7];
      end
      S_ADDR_ACK, S_READ, S_DATA_ACK: begin
        scl_low_d = (div_d < DIV_HALF);
      end
      S_STOP: begin
        scl_low_d = (div_d < DIV_HALF);
        sda_low_d = (div_d < DIV_SAMPLE);
      end
      default: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      rx_q       <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      sda_low_q  <= 1'b0;
      scl_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      sda_low_q  <= sda_low_d;
      scl_low_q  <= scl_low_d;
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
  assign i2c_scl  = scl_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: pulled-up bus, behavioural slave at 7'h2A, directed frames.
module tb_i2c_master_ctrl;

  localparam logic [6:0] SLAVE_ADDR = 7'h2A;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] addr;
  logic [7:0] data_in;
  logic       enable;
  logic       rw;
  logic [7:0] data_out;
  logic       ready;
  wire        sda_bus;
  wire        scl_bus;

  pullup (sda_bus);
  pullup (scl_bus);

  i2c_master_ctrl #(.DIVIDE_BY(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .enable  (enable),
    .rw      (rw),
    .data_out(data_out),
    .ready   (ready),
    .i2c_sda (sda_bus),
    .i2c_scl (scl_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: START/STOP conditions and the 9th/18th SCL rise of each frame.
  logic scl_p = 1'b1;
  logic sda_p = 1'b1;
  int   starts = 0;
  int   stops = 0;
  int   rises = 0;
  logic ack9 = 1'b0;
  logic ack18 = 1'b0;

  always @(negedge clk) begin
    if (scl_p && scl_bus && sda_p && !sda_bus) begin
      starts <= starts + 1;
      rises  <= 0;
    end else if (!scl_p && scl_bus) begin
      rises <= rises + 1;
      if (rises == 8)  ack9  <= sda_bus;
      if (rises == 17) ack18 <= sda_bus;
    end
    if (scl_p && scl_bus && !sda_p && sda_bus) stops <= stops + 1;
    scl_p <= scl_bus;
    sda_p <= sda_bus;
  end

  // Behavioural slave: changes SDA only just after SCL falls.
  localparam int P_IDLE = 0, P_ADDR = 1, P_AACK = 2, P_WDATA = 3, P_WACK = 4, P_READ = 5;
  int         sl_phase = P_IDLE;
  int         sl_cnt = 0;
  logic [7:0] sl_shift = 8'h00;
  logic [7:0] sl_txsh = 8'h00;
  logic       sl_rw = 1'b0;
  logic       sl_drive = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_tx;

  assign sda_bus = sl_drive ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    if (scl_p && scl_bus && sda_p && !sda_bus) begin
      sl_phase <= P_ADDR;
      sl_cnt   <= 0;
      sl_drive <= 1'b0;
    end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
      sl_phase <= P_IDLE;
      sl_drive <= 1'b0;
    end else if (!scl_p && scl_bus) begin
      if (sl_phase == P_ADDR || sl_phase == P_WDATA) begin
        sl_shift <= {sl_shift[6:0], sda_bus};
        sl_cnt   <= sl_cnt + 1;
      end else if (sl_phase == P_READ) begin
        sl_cnt <= sl_cnt + 1;
      end
    end else if (scl_p && !scl_bus) begin
      case (sl_phase)
        P_ADDR: if (sl_cnt == 8) begin
          if (sl_shift[7:1] == SLAVE_ADDR) begin
            sl_drive <= 1'b1;
            sl_rw    <= sl_shift[0];
            sl_phase <= P_AACK;
          end else begin
            sl_phase <= P_IDLE;
          end
        end
        P_AACK: begin
          sl_cnt <= 0;
          if (sl_rw) begin
            sl_phase <= P_READ;
            sl_drive <= ~slave_tx[7];
            sl_txsh  <= {slave_tx[6:0], 1'b0};
          end else begin
            sl_phase <= P_WDATA;
            sl_drive <= 1'b0;
          end
        end
        P_WDATA: if (sl_cnt == 8) begin
          slave_byte <= sl_shift;
          sl_drive   <= 1'b1;
          sl_phase   <= P_WACK;
        end
        P_WACK: begin
          sl_drive <= 1'b0;
          sl_phase <= P_IDLE;
        end
        P_READ: begin
          if (sl_cnt < 8) begin
            sl_drive <= ~sl_txsh[7];
            sl_txsh  <= {sl_txsh[6:0], 1'b0};
          end else begin
            sl_drive <= 1'b0;
            sl_phase <= P_IDLE;
          end
        end
        default: sl_phase <= P_IDLE;
      endcase
    end
  end

  // One request with a 5-cycle enable, inputs scrambled once enable drops.
  task automatic run_frame(input logic [6:0] a, input logic [7:0] d, input logic r,
                           output int low_cnt, output logic [7:0] dout_pre,
                           output logic [7:0] dout_post);
    addr     = a;
    data_in  = d;
    rw       = r;
    enable   = 1'b1;
    low_cnt  = 0;
    dout_pre = 8'h00;
    dout_post = 8'h00;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 5) begin
        enable  = 1'b0;
        addr    = 7'h7F;
        data_in = 8'h00;
        rw      = ~r;
      end
      if (ready && low_cnt > 0) break;
      if (!ready) low_cnt++;
      if (low_cnt == 72) dout_pre = data_out;
      if (low_cnt == 73) dout_post = data_out;
    end
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         low;
  int         exp_low;
  int         s0;
  int         p0;
  int         first_hi;
  int         second_hi;
  int         hi_cnt;
  logic       done;
  logic [7:0] pre;
  logic [7:0] post;

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    addr     = 7'h00;
    data_in  = 8'h00;
    rw       = 1'b0;
    slave_tx = 8'h5C;
    repeat (50) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dout", 32'(data_out), 32'h00);
    check("rst_sda", 32'(sda_bus), 32'd1);
    check("rst_scl", 32'(scl_bus), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);

    // Write 8'hAA
    run_frame(SLAVE_ADDR, 8'hAA, 1'b0, low, pre, post);
    check("wr_low", 32'(low), 32'd80);
    check("wr_byte", 32'(slave_byte), 32'hAA);
    check("wr_ready", 32'(ready), 32'd1);

    // Write 8'h3C, bus-level framing
    s0 = starts;
    p0 = stops;
    run_frame(SLAVE_ADDR, 8'h3C, 1'b0, low, pre, post);
    check("wr2_low", 32'(low), 32'd80);
    check("wr2_starts", 32'(starts - s0), 32'd1);
    check("wr2_stops", 32'(stops - p0), 32'd1);
    check("wr2_addr_ack", 32'(ack9), 32'd0);
    check("wr2_data_ack", 32'(ack18), 32'd0);
    check("wr2_byte", 32'(slave_byte), 32'h3C);

    // Read 8'h5C, then 8'hC3
    slave_tx = 8'h5C;
    run_frame(SLAVE_ADDR, 8'hFF, 1'b1, low, pre, post);
    check("rd_low", 32'(low), 32'd80);
    check("rd_dout_before", 32'(pre), 32'h00);
    check("rd_dout_after", 32'(post), 32'h5C);
    check("rd_dout_idle", 32'(data_out), 32'h5C);
    check("rd_addr_ack", 32'(ack9), 32'd0);
    check("rd_master_nack", 32'(ack18), 32'd1);
    check("rd_wr_byte_kept", 32'(slave_byte), 32'h3C);
    slave_tx = 8'hC3;
    run_frame(SLAVE_ADDR, 8'h00, 1'b1, low, pre, post);
    check("rd2_dout_before", 32'(pre), 32'h5C);
    check("rd2_dout_after", 32'(post), 32'hC3);

    // No slave at 7'h11
`ifdef I2C_NACK_ABORT_EN
    exp_low = 44;
`else
    exp_low = 80;
`endif
    s0 = starts;
    p0 = stops;
    run_frame(7'h11, 8'h55, 1'b0, low, pre, post);
    check("nack_low", 32'(low), 32'(exp_low));
    check("nack_bit", 32'(ack9), 32'd1);
    check("nack_starts", 32'(starts - s0), 32'd1);
    check("nack_stops", 32'(stops - p0), 32'd1);
    check("nack_dout", 32'(data_out), 32'hC3);
    check("nack_slave_byte", 32'(slave_byte), 32'h3C);
    check("nack_ready", 32'(ready), 32'd1);

    // Reset during WRITE_DATA
    p0      = stops;
    addr    = SLAVE_ADDR;
    data_in = 8'h96;
    rw      = 1'b0;
    enable  = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 5) enable = 1'b0;
    end
    check("mid_busy", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sda", 32'(sda_bus), 32'd1);
    check("mid_rst_scl", 32'(scl_bus), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_dout", 32'(data_out), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst_hold", 32'(ready), 32'd0);
    @(negedge clk);
    check("mid_rst_release", 32'(ready), 32'd1);
    check("mid_rst_no_stop", 32'(stops - p0), 32'd0);

    // enable held for 200 cycles: back-to-back frames
    s0        = starts;
    addr      = SLAVE_ADDR;
    data_in   = 8'h69;
    rw        = 1'b0;
    enable    = 1'b1;
    first_hi  = 0;
    second_hi = 0;
    hi_cnt    = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ready) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = i;
        else if (second_hi == 0) second_hi = i;
      end
    end
    enable = 1'b0;
    done   = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        break;
      end
    end
    check("b2b_first_gap", 32'(first_hi), 32'd81);
    check("b2b_second_gap", 32'(second_hi), 32'd162);
    check("b2b_high_cycles", 32'(hi_cnt), 32'd2);
    check("b2b_idle_return", 32'(done), 32'd1);
    check("b2b_starts", 32'(starts - s0), 32'd3);
    check("b2b_byte", 32'(slave_byte), 32'h69);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
